l1i_cache: RTL and testbench



---
 rtl/l1i_cache_if.sv | 20 ++
 rtl/l1i_cache.sv | 112 +++++++++++
 tb/tb_l1i_cache.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1i_cache_if.sv
// L2 refill bus between the instruction cache (master) and the L2 (slave).
// Request is held until accepted (L2_stall low); responses are single-cycle strobes.
interface l1i_cache_if;
  logic         L2_req;
  logic [31:0]  L2_req_addr;
  logic         L2_stall;
  logic         L2_valid;
  logic [31:0]  L2_addr_read;
  logic [255:0] L2_block_read;

  modport master (
    output L2_req, L2_req_addr,
    input  L2_stall, L2_valid, L2_addr_read, L2_block_read
  );

  modport slave (
    input  L2_req, L2_req_addr,
    output L2_stall, L2_valid, L2_addr_read, L2_block_read
  );
endinterface

// File: rtl/l1i_cache.sv
// Direct-mapped L1 I-cache: word returned the cycle after addr is captured, NOP+stall on miss.
// Refills 256-bit blocks from L2; request held stable while L2_stall, minimum miss penalty 3 cycles.
module l1i_cache #(
  parameter int          LINES = 32,
  parameter logic [31:0] NOP   = 32'h00000033
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  output logic [31:0] out,
  output logic        stall,
  input  logic        inv,
  l1i_cache_if.master l2
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 27 - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
    logic [1:0]       bo;
  } faddr_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           state;
  faddr_t           r_addr;
  faddr_t           pend_addr;
  faddr_t           blk_addr;
  logic             discard;
  logic [LINES-1:0] valid;
  logic [255:0]     data_mem [LINES];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic             hit;
  logic             fill_hit;
  logic             fill_we;
  logic [255:0]     sel_line;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^r_addr.bo;
  assign blk_addr = {r_addr.tag, r_addr.idx, 5'd0};

  assign hit      = valid[r_addr.idx] && (tag_mem[r_addr.idx] == r_addr.tag);
  assign sel_line = data_mem[r_addr.idx];
  assign out      = hit ? sel_line[{r_addr.off, 5'd0} +: 32] : NOP;
  assign stall    = !hit;

  // Only the response for the block we asked for may fill; fence.i or a pending discard drops it.
  assign fill_hit = (state == S_WAIT) && l2.L2_valid && (l2.L2_addr_read == pend_addr);
  assign fill_we  = fill_hit && !discard && !inv;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[pend_addr.idx] <= l2.L2_block_read;
      tag_mem[pend_addr.idx]  <= pend_addr.tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      r_addr         <= '0;
      pend_addr      <= '0;
      discard        <= 1'b0;
      valid          <= '0;
      l2.L2_req      <= 1'b0;
      l2.L2_req_addr <= '0;
    end else begin
      r_addr <= addr;

      if (inv)
        valid <= '0;
      else if (fill_we)
        valid[pend_addr.idx] <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!inv && !hit) begin
            pend_addr      <= blk_addr;
            l2.L2_req_addr <= blk_addr;
            l2.L2_req      <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (inv)
            discard <= 1'b1;
          if (!l2.L2_stall) begin
            l2.L2_req <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fill_hit) begin
            discard <= 1'b0;
            state   <= S_IDLE;
          end else if (inv) begin
            discard <= 1'b1;
          end
        end
        default: begin
          l2.L2_req <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1i_cache.sv
// Directed bench for l1i_cache with a behavioural L2 (configurable latency, optional bogus response).
// Instruction word at byte address a is {a[31:2],2'b00} ^ 32'h00500093, so word 0 of block 0 is 00500093.
module tb_l1i_cache;
  localparam logic [31:0] NOP = 32'h00000033;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr  = 32'd0;
  logic        inv   = 1'b0;
  logic [31:0] out;
  logic        stall;

  l1i_cache_if l2 ();

  l1i_cache #(.LINES(32), .NOP(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .out   (out),
    .stall (stall),
    .inv   (inv),
    .l2    (l2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_acc = 0;
  int acc0  = 0;
  int l2_lat = 0;
  bit inject_wrong = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wexp(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h00500093;
  endfunction

  function automatic logic [255:0] mk_block(input logic [31:0] a);
    logic [255:0] b;
    b = '0;
    for (int w = 0; w < 8; w++)
      b[32*w +: 32] = wexp(a + 32'(w * 4));
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_hit(input string tag);
    int n;
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(stall), 32'd0);
  endtask

  // Behavioural L2: accepts on an edge with req && !stall, answers after l2_lat idle cycles.
  initial begin : l2_model
    logic [31:0] a;
    l2.L2_valid      = 1'b0;
    l2.L2_addr_read  = 32'd0;
    l2.L2_block_read = '0;
    forever begin
      @(negedge clk);
      if (rst_n && l2.L2_req && !l2.L2_stall) begin
        a = l2.L2_req_addr;
        n_acc++;
        @(posedge clk);
        #1;
        if (inject_wrong) begin
          l2.L2_valid      = 1'b1;
          l2.L2_addr_read  = 32'h20;
          l2.L2_block_read = '1;
          @(posedge clk);
          #1;
        end
        l2.L2_valid = 1'b0;
        repeat (l2_lat) begin
          @(posedge clk);
          #1;
        end
        l2.L2_valid      = 1'b1;
        l2.L2_addr_read  = a;
        l2.L2_block_read = mk_block(a);
        @(posedge clk);
        #1;
        l2.L2_valid = 1'b0;
      end
    end
  end

  initial begin
    l2.L2_stall = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_stall", 32'(stall), 32'd1);
    check("rst_out", out, NOP);
    check("rst_req", 32'(l2.L2_req), 32'd0);
    check("rst_req_addr", l2.L2_req_addr, 32'd0);

    // Cold start: exactly 3 stall cycles
    rst_n = 1'b1;
    check("cold_c1_stall", 32'(stall), 32'd1);
    check("cold_c1_out", out, NOP);
    tick();
    check("cold_c2_stall", 32'(stall), 32'd1);
    check("cold_c2_req", 32'(l2.L2_req), 32'd1);
    check("cold_c2_req_addr", l2.L2_req_addr, 32'd0);
    tick();
    check("cold_c3_stall", 32'(stall), 32'd1);
    check("cold_c3_req", 32'(l2.L2_req), 32'd0);
    tick();
    check("cold_c4_stall", 32'(stall), 32'd0);
    check("cold_c4_out", out, 32'h00500093);

    // Sequential hits through block 0
    for (int i = 1; i < 8; i++) begin
      addr = 32'(i * 4);
      tick();
      check("seq_out", out, wexp(32'(i * 4)));
      check("seq_stall", 32'(stall), 32'd0);
      check("seq_req", 32'(l2.L2_req), 32'd0);
    end
    check("seq_accepts", 32'(n_acc), 32'd1);

    // Conflict miss: 0x400 shares index 0 with 0x000
    addr = 32'h400;
    tick();
    check("conf_miss", 32'(stall), 32'd1);
    tick();
    check("conf_req_addr", l2.L2_req_addr, 32'h400);
    wait_hit("conf_fill");
    check("conf_out", out, wexp(32'h400));
    addr = 32'h0;
    tick();
    check("conf_remiss", 32'(stall), 32'd1);
    tick();
    check("conf_req_addr0", l2.L2_req_addr, 32'h0);
    wait_hit("conf_refill");
    check("conf_out0", out, 32'h00500093);

    // Backpressure 5 cycles in REQ, then a bogus response before the real one
    acc0 = n_acc;
    l2.L2_stall  = 1'b1;
    inject_wrong = 1'b1;
    addr = 32'h80;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_req", 32'(l2.L2_req), 32'd1);
      check("bp_req_addr", l2.L2_req_addr, 32'h80);
      if (i < 4) tick();
    end
    l2.L2_stall = 1'b0;
    tick();
    check("bp_wait_req", 32'(l2.L2_req), 32'd0);
    check("bp_wait_stall", 32'(stall), 32'd1);
    tick();
    check("bp_wrong_ignored", 32'(stall), 32'd1);
    tick();
    check("bp_hit", 32'(stall), 32'd0);
    check("bp_out", out, wexp(32'h80));
    check("bp_one_accept", 32'(n_acc - acc0), 32'd1);
    inject_wrong = 1'b0;

    // Redirect while in WAIT: 0x100 still fills, then 0x200 is fetched
    acc0 = n_acc;
    addr = 32'h100;
    tick();
    tick();
    check("redir_req_addr1", l2.L2_req_addr, 32'h100);
    tick();
    addr = 32'h200;
    check("redir_wait_stall", 32'(stall), 32'd1);
    tick();
    check("redir_new_miss", 32'(stall), 32'd1);
    check("redir_new_out", out, NOP);
    tick();
    check("redir_req_addr2", l2.L2_req_addr, 32'h200);
    wait_hit("redir_fill2");
    check("redir_out2", out, wexp(32'h200));
    addr = 32'h104;
    tick();
    check("redir_old_line_hit", 32'(stall), 32'd0);
    check("redir_old_line_out", out, wexp(32'h104));
    check("redir_accepts", 32'(n_acc - acc0), 32'd2);

    // inv during WAIT: refill dropped, same address re-requested
    acc0 = n_acc;
    l2_lat = 2;
    addr = 32'h300;
    tick();
    tick();
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    check("inv_wait_stall", 32'(stall), 32'd1);
    tick();
    check("inv_resp_stall", 32'(stall), 32'd1);
    tick();
    check("inv_dropped", 32'(stall), 32'd1);
    check("inv_idle_req", 32'(l2.L2_req), 32'd0);
    tick();
    check("inv_rereq", 32'(l2.L2_req), 32'd1);
    check("inv_rereq_addr", l2.L2_req_addr, 32'h300);
    wait_hit("inv_refill");
    check("inv_out", out, wexp(32'h300));
    check("inv_accepts", 32'(n_acc - acc0), 32'd2);
    addr = 32'h80;
    tick();
    check("inv_cleared_other", 32'(stall), 32'd1);
    wait_hit("inv_refill_80");
    l2_lat = 0;

    // inv on the same edge as the fill: line stays invalid
    addr = 32'h340;
    tick();
    tick();
    tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    check("invfill_stall", 32'(stall), 32'd1);
    tick();
    check("invfill_rereq", 32'(l2.L2_req), 32'd1);
    check("invfill_rereq_addr", l2.L2_req_addr, 32'h340);
    wait_hit("invfill_refill");
    check("invfill_out", out, wexp(32'h340));

    // inv in IDLE has priority over starting a refill
    inv = 1'b1;
    tick();
    check("invidle_miss", 32'(stall), 32'd1);
    tick();
    check("invidle_no_req", 32'(l2.L2_req), 32'd0);
    inv = 1'b0;
    tick();
    check("invidle_req", 32'(l2.L2_req), 32'd1);
    wait_hit("invidle_refill");

    // Async reset while REQ is held by L2_stall
    l2.L2_stall = 1'b1;
    addr = 32'h3c0;
    tick();
    tick();
    check("arst_pre_req", 32'(l2.L2_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_req", 32'(l2.L2_req), 32'd0);
    check("arst_req_addr", l2.L2_req_addr, 32'd0);
    check("arst_stall", 32'(stall), 32'd1);
    tick();
    l2.L2_stall = 1'b0;
    rst_n = 1'b1;
    wait_hit("arst_refill");
    check("arst_out", out, wexp(32'h3c0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
